// File: rtl/sh_ram_clr.sv
// sh_ram_clr: dual-port RAM with hardware clear engine.
// Port A writes and reads; port B reads with a valid strobe.
module sh_ram_clr #(
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   parameter bit                    OUT_REG    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   output logic                  wr_drop,
   input  logic                  re_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] dout_b,
   output logic                  dout_b_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_nxt;

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;

   logic [ADDR_WIDTH-1:0] addr_a_reg;
   logic [ADDR_WIDTH-1:0] addr_b_reg;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;

   assign busy = (state == S_CLEAR);

   // Next state and the single RAM write port: clear engine or port A
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ram_we    = 1'b0;
      ram_addr  = addr_a;
      ram_din   = din_a;
      unique case (state)
         S_CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = cnt;
            ram_din  = INIT_VALUE;
            cnt_nxt  = cnt + 1'b1;
            if (&cnt) begin
               state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            ram_we = we_a;
            if (clr_req) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

   // FSM state and clear counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Array write; contents survive reset and are wiped by the clear
   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         ram[ram_addr] <= ram_din;
      end
   end

   // Read address registers, dropped-write pulse, first valid stage
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a_reg <= '0;
         addr_b_reg <= '0;
         wr_drop    <= 1'b0;
         rd_valid   <= 1'b0;
      end else begin
         addr_a_reg <= addr_a;
         addr_b_reg <= addr_b;
         wr_drop    <= we_a && busy;
         rd_valid   <= re_b && !busy;
      end
   end

   // Reading through registered addresses makes same-cycle writes visible
   assign rd_a = ram[addr_a_reg];
   assign rd_b = ram[addr_b_reg];

   generate
      if (OUT_REG) begin : g_oreg
         logic [DATA_WIDTH-1:0] qa;
         logic [DATA_WIDTH-1:0] qb;
         logic                  qv;

         // Optional output register stage on both ports
         always_ff @(posedge clk) begin
            if (rst) begin
               qa <= '0;
               qb <= '0;
               qv <= 1'b0;
            end else begin
               qa <= rd_a;
               qb <= rd_b;
               qv <= rd_valid;
            end
         end

         assign dout_a       = qa;
         assign dout_b       = qb;
         assign dout_b_valid = qv;
      end else begin : g_comb
         assign dout_a       = rd_a;
         assign dout_b       = rd_b;
         assign dout_b_valid = rd_valid;
      end
   endgenerate

endmodule

// File: tb/tb_sh_ram_clr.sv
// tb_sh_ram_clr: drives OUT_REG=0 and OUT_REG=1 copies with the
// same stimulus and checks both against a behavioural model.
module tb_sh_ram_clr;

   localparam int         AW    = 4;
   localparam int         DW    = 8;
   localparam int         DEPTH = 16;
   localparam logic [7:0] INIT  = 8'hA5;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          clr_req = 1'b0;
   logic          we_a    = 1'b0;
   logic          re_b    = 1'b0;
   logic [AW-1:0] addr_a  = '0;
   logic [AW-1:0] addr_b  = '0;
   logic [DW-1:0] din_a   = '0;

   logic          busy0, busy1, drop0, drop1, bv0, bv1;
   logic [DW-1:0] da0, da1, db0, db1;

   always #5 clk = ~clk;

   sh_ram_clr #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .INIT_VALUE(INIT), .OUT_REG(1'b0)
   ) u0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
      .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(da0),
      .wr_drop(drop0), .re_b(re_b), .addr_b(addr_b),
      .dout_b(db0), .dout_b_valid(bv0)
   );

   sh_ram_clr #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .INIT_VALUE(INIT), .OUT_REG(1'b1)
   ) u1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
      .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(da1),
      .wr_drop(drop1), .re_b(re_b), .addr_b(addr_b),
      .dout_b(db1), .dout_b_valid(bv1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: memory image, busy countdown, expected outputs
   logic [DW-1:0] mem [DEPTH];
   bit            mbusy = 1'b1;
   int            rem   = DEPTH;
   bit            e_drop;
   bit            e0_bv, e0_bchk, e0_achk;
   bit            e1_bv, e1_bchk, e1_achk;
   logic [DW-1:0] e0_b, e0_a, e1_b, e1_a;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // one clock: update the model for the edge, then compare outputs
   task automatic step();
      bit bb;
      @(posedge clk);
      #1;
      bb      = mbusy;
      e1_bv   = e0_bv;
      e1_bchk = e0_bchk;
      e1_b    = e0_b;
      e1_achk = e0_achk;
      e1_a    = e0_a;
      if (rst) begin
         mbusy   = 1'b1;
         rem     = DEPTH;
         e_drop  = 1'b0;
         e0_bv   = 1'b0;
         e0_bchk = 1'b0;
         e0_achk = 1'b0;
         e1_bv   = 1'b0;
         e1_bchk = 1'b1;
         e1_b    = '0;
         e1_achk = 1'b1;
         e1_a    = '0;
      end else begin
         e_drop = we_a && bb;
         if (bb) begin
            rem--;
            if (rem == 0) begin
               mbusy = 1'b0;
               foreach (mem[i]) mem[i] = INIT;
            end
         end else begin
            if (we_a) mem[addr_a] = din_a;
            if (clr_req) begin
               mbusy = 1'b1;
               rem   = DEPTH;
            end
         end
         e0_bv   = re_b && !bb;
         e0_bchk = e0_bv;
         e0_b    = mem[addr_b];
         e0_achk = !mbusy;
         e0_a    = mem[addr_a];
      end
      chk("busy0", busy0, mbusy);
      chk("busy1", busy1, mbusy);
      chk("drop0", drop0, e_drop);
      chk("drop1", drop1, e_drop);
      chk("bval0", bv0, e0_bv);
      chk("bval1", bv1, e1_bv);
      if (e0_bchk) chk("doutb0", db0, e0_b);
      if (e1_bchk) chk("doutb1", db1, e1_b);
      if (e0_achk) chk("douta0", da0, e0_a);
      if (e1_achk) chk("douta1", da1, e1_a);
   endtask

   task automatic quiet();
      clr_req = 1'b0;
      we_a    = 1'b0;
      re_b    = 1'b0;
   endtask

   // count edges until busy drops, bounded
   task automatic wait_idle(inout int n);
      while (busy0 && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) begin
         re_b   = 1'b1;
         addr_b = AW'(i);
         step();
      end
      re_b = 1'b0;
      step();
      step();
   endtask

   initial begin
      int n;
      int nwr;
      int ndrop;
      foreach (mem[i]) mem[i] = '0;

      // reset and power-on clear
      repeat (3) step();
      rst = 1'b0;
      n   = 0;
      step();
      n++;
      wait_idle(n);
      chk("rst_clear_len", n, DEPTH);
      read_all();

      // write and read back
      we_a = 1'b1; addr_a = 4'd3;  din_a = 8'h3C; step();
      we_a = 1'b1; addr_a = 4'd15; din_a = 8'hF0; step();
      we_a = 1'b0;
      re_b = 1'b1; addr_b = 4'd3;  step();
      re_b = 1'b1; addr_b = 4'd15; step();
      re_b = 1'b0; step(); step();

      // same-cycle write and read of one address
      we_a = 1'b1; addr_a = 4'd5; din_a = 8'h77;
      re_b = 1'b1; addr_b = 4'd5;
      step();
      quiet(); step(); step();
      chk("collide_b1", db1, 8'h77);

      // fill with address values, then clear under traffic
      for (int i = 0; i < DEPTH; i++) begin
         we_a = 1'b1; addr_a = AW'(i); din_a = DW'(i);
         step();
      end
      quiet();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      nwr   = 0;
      ndrop = 0;
      for (int i = 0; i < 10; i++) begin
         we_a   = 1'($urandom_range(0, 1));
         re_b   = 1'($urandom_range(0, 1));
         addr_a = AW'($urandom_range(0, DEPTH - 1));
         addr_b = AW'($urandom_range(0, DEPTH - 1));
         din_a  = DW'($urandom);
         if (we_a) nwr++;
         step();
         if (drop0) ndrop++;
      end
      quiet();
      n = 0;
      while (busy0 && n < 100) begin
         step();
         n++;
         if (drop0) ndrop++;
      end
      step();
      if (drop0) ndrop++;
      chk("drop_count", ndrop, nwr);
      read_all();

      // second request mid-clear is ignored
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      n = 0;
      repeat (7) begin
         step();
         n++;
      end
      clr_req = 1'b1;
      step();
      n++;
      clr_req = 1'b0;
      wait_idle(n);
      chk("ignored_req_len", n, DEPTH);

      // reset in the middle of a clear restarts it
      we_a = 1'b1; addr_a = 4'd9; din_a = 8'h42; step();
      quiet();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n   = 0;
      step();
      n++;
      wait_idle(n);
      chk("rst_mid_len", n, DEPTH);
      read_all();

      // random traffic with occasional clear and reset
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 249) == 0);
         clr_req = ($urandom_range(0, 49) == 0);
         we_a    = 1'($urandom_range(0, 1));
         re_b    = 1'($urandom_range(0, 1));
         addr_a  = AW'($urandom_range(0, DEPTH - 1));
         addr_b  = ($urandom_range(0, 3) == 0) ? addr_a
                                               : AW'($urandom_range(0, DEPTH - 1));
         din_a   = DW'($urandom);
         step();
      end
      rst = 1'b0;
      quiet();
      n = 0;
      wait_idle(n);
      read_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sh_ram_clr.md
# sh_ram_clr

Parametrised dual-port RAM with a built-in clear engine and a handshaked read port. Port A is write-plus-read; port B is read-only with a valid strobe. A hardware FSM fills every location with `INIT_VALUE` after reset or on request. It sits between the sensor/speed sampling logic and the display/statistics readers, so history buffers start from a known state without software loops.

## Interface
Parameters:
- `ADDR_WIDTH`, 4, address bits; DEPTH = 2**ADDR_WIDTH; legal 2..10
- `DATA_WIDTH`, 8, word width
- `INIT_VALUE`, 0, word written to every location by a clear
- `OUT_REG`, 0, 1 adds an output register on both read ports

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `clr_req`  in  1  start a full clear (sampled in IDLE only)
- `busy`  out  1  high while clear in progress
- `we_a`  in  1  port A write enable
- `addr_a`  in  ADDR_WIDTH  port A address
- `din_a`  in  DATA_WIDTH  port A write data
- `dout_a`  out  DATA_WIDTH  port A read data
- `wr_drop`  out  1  one-cycle pulse: a write was discarded because `busy`
- `re_b`  in  1  port B read request
- `addr_b`  in  ADDR_WIDTH  port B address
- `dout_b`  out  DATA_WIDTH  port B read data
- `dout_b_valid`  out  1  `dout_b` holds data for an accepted `re_b`

## Operation
- FSM states: CLEAR, IDLE. A clear counter `cnt` is ADDR_WIDTH bits wide.
- `rst`=1: state←CLEAR, `cnt`←0, addr registers←0, output registers←0, `dout_b_valid`←0, `wr_drop`←0. The RAM array is not reset.
- CLEAR, each cycle:
  - write `INIT_VALUE` to ram[`cnt`], then `cnt`←`cnt`+1.
  - At `cnt`=DEPTH−1, write the last location and go to IDLE. No wrap, no second pass.
- IDLE:
  - `clr_req`=1 → CLEAR with `cnt`←0.
  - `we_a`=1 writes `din_a` to ram[`addr_a`]. This happens even when `clr_req` is high in the same cycle; the clear then overwrites it.
- `busy` = (state==CLEAR), registered.
- `clr_req` while in CLEAR is ignored; the clear is not restarted.
- `we_a` while `busy`: the write is discarded and `wr_drop`=1 the next cycle. `wr_drop`=0 otherwise.
- Port A read:
  - `addr_a` is registered every cycle.
  - `dout_a` = ram[addr_a_reg], combinational when `OUT_REG`=0, registered again when `OUT_REG`=1.
  - No valid signal.
  - Contents are undefined while `busy`.
- Port B read:
  - `addr_b` is registered every cycle.
  - `re_b` is accepted only when `busy`=0. An accepted read sets the valid pipeline.
  - `re_b` while `busy` is dropped silently; no valid is produced.
  - `dout_b_valid` is a per-request pulse, not held.
  - Back-to-back `re_b` gives back-to-back valids.
- Collision, same address on A write and B read in the same cycle: B returns new data (write-first). This follows from the registered-address read.
- `rst` mid-clear: the clear restarts from address 0 when `rst` falls.

## Timing
- Clear duration: `busy`=1 from the first edge with `rst` high through exactly DEPTH cycles after `rst` falls. `busy` falls on the edge after ram[DEPTH−1] is written.
- Clear on request: `clr_req` sampled high in IDLE at edge N gives `busy`=1 from N+1 to N+DEPTH. `busy`=0 at N+DEPTH+1.
- Read latency, address sampled at edge N:
  - `OUT_REG`=0: data valid after edge N, so `dout_b_valid` is high in cycle N+1.
  - `OUT_REG`=1: data valid after edge N+1, so `dout_b_valid` is high in cycle N+2.
  - `dout_a` follows the same latency.
- Write latency: data written at edge N is readable by an address sampled at edge N, since the array is read after the update. Read-after-write therefore needs 0 extra cycles.
- Reset values: `busy`=1, `wr_drop`=0, `dout_b_valid`=0. `dout_a`/`dout_b` are 0 when `OUT_REG`=1, and ram[0] (undefined until cleared) when `OUT_REG`=0.

## Test plan
- Reset clear, ADDR_WIDTH=4, INIT_VALUE=8'hA5: release `rst` → `busy` high exactly 16 cycles. Then read all 16 addresses on B → every `dout_b`=A5, each with one `dout_b_valid` pulse.
- Write/readback, OUT_REG=0 and 1: write addr 3←8'h3C, addr 15←8'hF0. `re_b` to addr 3 then 15 → 3C then F0, `dout_b_valid` 1 and 2 cycles after request respectively.
- Collision: A writes 8'h77 to addr 5 while B reads addr 5 in the same cycle → `dout_b`=77.
- Clear request with traffic: fill addr 0..15 with the address value, pulse `clr_req`. Issue `we_a` and `re_b` during `busy` → `wr_drop` pulses once per write, no `dout_b_valid`. Afterwards all reads return INIT_VALUE.
- `clr_req` ignored in CLEAR: pulse again at `cnt`=7 → `busy` still falls 16 cycles after the first request.
- Reset mid-clear: assert `rst` one cycle at `cnt`=10 → `busy` stays high for 16 cycles after `rst` falls. Final contents are all INIT_VALUE.
